// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush control for the 5-stage RV32I core
// Optional stall/flush performance counters: HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
  parameter int DATA_W = 32
`ifdef HAZARD_STALL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic              icache_resp,
  input  logic [DATA_W-1:0] icache_rdata,
  input  logic              dcache_req,
  input  logic              dcache_resp,
  input  logic              idex_is_load,
  input  logic [4:0]        idex_rd,
  input  logic [4:0]        ifid_rs1,
  input  logic [4:0]        ifid_rs2,
  input  logic              ifid_uses_rs1,
  input  logic              ifid_uses_rs2,
  input  logic              br_taken,
  output logic              icache_req_en,
  output logic              dcache_req_en,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [18:0]       pipe_ctrl,
  output logic              pc_ld,
  output logic              ifid_flush,
  output logic              idex_flush
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_mem_cnt,
  output logic [CNT_W-1:0]  stall_lu_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // ifid_ireg_ld and ifid_pcreg_ld occupy the two MSBs of pipe_ctrl
  localparam logic [18:0] ALL_LD  = 19'h7FFFF;
  localparam logic [18:0] IFID_LD = 19'h60000;

  typedef enum logic {RUN, WAIT} state_t;

  state_t            state, state_next;
  logic              i_done, d_done;
  logic [DATA_W-1:0] ibuf;
  logic              i_pend, d_pend, mem_busy, advance, lu;

  assign i_pend   = icache_read & ~i_done & ~icache_resp;
  assign d_pend   = dcache_req & ~d_done & ~dcache_resp;
  assign mem_busy = i_pend | d_pend;
  assign advance  = ~mem_busy;

  assign lu = idex_is_load & (idex_rd != 5'd0) &
              ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
               (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

  assign ifid_instr = i_done ? ibuf : icache_rdata;

  always_comb begin
    state_next    = state;
    pipe_ctrl     = '0;
    pc_ld         = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    icache_req_en = ~i_done;
    dcache_req_en = ~d_done;

    case (state)
      RUN:     state_next = mem_busy ? WAIT : RUN;
      WAIT:    state_next = advance ? RUN : WAIT;
      default: state_next = RUN;
    endcase

    if (rst) begin
      state_next    = RUN;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      icache_req_en = 1'b0;
      dcache_req_en = 1'b0;
    end else if (mem_busy) begin
      // whole pipeline frozen; hazards are re-evaluated once memory is done
      pipe_ctrl = '0;
    end else if (br_taken) begin
      pipe_ctrl  = ALL_LD;
      pc_ld      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      // hold PC and IF/ID, inject a bubble into ID/EX
      pipe_ctrl  = ALL_LD & ~IFID_LD;
      idex_flush = 1'b1;
    end else begin
      pipe_ctrl = ALL_LD;
      pc_ld     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
      ibuf   <= '0;
    end else begin
      state <= state_next;
      if (mem_busy) begin
        if (icache_resp) begin
          i_done <= 1'b1;
          ibuf   <= icache_rdata;
        end
        if (dcache_resp) begin
          d_done <= 1'b1;
        end
      end else begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_mem_cnt <= '0;
      stall_lu_cnt  <= '0;
      flush_cnt     <= '0;
    end else begin
      if (mem_busy)                   stall_mem_cnt <= stall_mem_cnt + 1'b1;
      if (advance & lu & ~br_taken)   stall_lu_cnt  <= stall_lu_cnt + 1'b1;
      if (advance & br_taken)         flush_cnt     <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
// Optional counter checks compiled in with HAZARD_STALL_PERF_EN.
module tb_hazard_stall_ctrl;

  logic        clk, rst;
  logic        icache_read, icache_resp, dcache_req, dcache_resp;
  logic [31:0] icache_rdata;
  logic        idex_is_load, ifid_uses_rs1, ifid_uses_rs2, br_taken;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        icache_req_en, dcache_req_en, pc_ld, ifid_flush, idex_flush;
  logic [31:0] ifid_instr;
  logic [18:0] pipe_ctrl;
`ifdef HAZARD_STALL_PERF_EN
  logic [3:0]  stall_mem_cnt, stall_lu_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic go = 1'b0;
  logic done = 1'b0;

  hazard_stall_ctrl #(
    .DATA_W(32)
`ifdef HAZARD_STALL_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .idex_is_load(idex_is_load), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .br_taken(br_taken),
    .icache_req_en(icache_req_en), .dcache_req_en(dcache_req_en),
    .ifid_instr(ifid_instr), .pipe_ctrl(pipe_ctrl), .pc_ld(pc_ld),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush)
`ifdef HAZARD_STALL_PERF_EN
    , .stall_mem_cnt(stall_mem_cnt), .stall_lu_cnt(stall_lu_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: what each cycle must look like, classified by situation
  typedef enum {SIT_RESET, SIT_FROZEN, SIT_REDIRECT, SIT_LOADUSE, SIT_NORMAL} sit_t;

  initial begin : model_compare
    logic        m_i_done, m_d_done, busy, hz;
    logic [31:0] m_ibuf;
    logic [18:0] e_pipe;
    logic        e_pc, e_iff, e_idf;
    sit_t        sit;
`ifdef HAZARD_STALL_PERF_EN
    int          m_mem, m_lu, m_fl;
    m_mem = 0; m_lu = 0; m_fl = 0;
`endif
    m_i_done = 1'b0; m_d_done = 1'b0; m_ibuf = 32'h0;
    wait (go);
    while (!done) begin
      @(negedge clk);
      busy = (icache_read && !m_i_done && !icache_resp) ||
             (dcache_req && !m_d_done && !dcache_resp);
      hz = idex_is_load && idex_rd != 0 &&
           ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
      if (rst)           sit = SIT_RESET;
      else if (busy)     sit = SIT_FROZEN;
      else if (br_taken) sit = SIT_REDIRECT;
      else if (hz)       sit = SIT_LOADUSE;
      else               sit = SIT_NORMAL;
      case (sit)
        SIT_RESET:    begin e_pipe = 19'h00000; e_pc = 0; e_iff = 1; e_idf = 1; end
        SIT_FROZEN:   begin e_pipe = 19'h00000; e_pc = 0; e_iff = 0; e_idf = 0; end
        SIT_REDIRECT: begin e_pipe = 19'h7FFFF; e_pc = 1; e_iff = 1; e_idf = 1; end
        SIT_LOADUSE:  begin e_pipe = 19'h1FFFF; e_pc = 0; e_iff = 0; e_idf = 1; end
        default:      begin e_pipe = 19'h7FFFF; e_pc = 1; e_iff = 0; e_idf = 0; end
      endcase
      chk("m_pipe_ctrl", {13'h0, pipe_ctrl}, {13'h0, e_pipe});
      chk("m_pc_ld", {31'h0, pc_ld}, {31'h0, e_pc});
      chk("m_ifid_flush", {31'h0, ifid_flush}, {31'h0, e_iff});
      chk("m_idex_flush", {31'h0, idex_flush}, {31'h0, e_idf});
      chk("m_icache_req_en", {31'h0, icache_req_en}, {31'h0, !rst && !m_i_done});
      chk("m_dcache_req_en", {31'h0, dcache_req_en}, {31'h0, !rst && !m_d_done});
      chk("m_ifid_instr", ifid_instr, m_i_done ? m_ibuf : icache_rdata);
`ifdef HAZARD_STALL_PERF_EN
      chk("m_stall_mem_cnt", {28'h0, stall_mem_cnt}, m_mem % 16);
      chk("m_stall_lu_cnt", {28'h0, stall_lu_cnt}, m_lu % 16);
      chk("m_flush_cnt", {28'h0, flush_cnt}, m_fl % 16);
      if (rst) begin m_mem = 0; m_lu = 0; m_fl = 0; end
      else if (sit == SIT_FROZEN) m_mem++;
      else if (sit == SIT_REDIRECT) m_fl++;
      else if (sit == SIT_LOADUSE) m_lu++;
`endif
      // state as seen after the coming clock edge
      if (rst) begin
        m_i_done = 0; m_d_done = 0; m_ibuf = 0;
      end else if (busy) begin
        if (icache_resp) begin m_i_done = 1; m_ibuf = icache_rdata; end
        if (dcache_resp) m_d_done = 1;
      end else begin
        m_i_done = 0; m_d_done = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    icache_read = 0; icache_resp = 0; icache_rdata = 32'h0;
    dcache_req = 0; dcache_resp = 0;
    idex_is_load = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; br_taken = 0;
  endtask

  initial begin : stimulus
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    go = 1'b1;
    #1;
    chk("reset_pipe_ctrl", {13'h0, pipe_ctrl}, 32'h0);
    chk("reset_flushes", {30'h0, ifid_flush, idex_flush}, 32'h3);
    chk("reset_req_en", {30'h0, icache_req_en, dcache_req_en}, 32'h0);

    // icache response arrives three cycles late
    next_cycle();
    rst = 0; icache_read = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("late_i_frozen", {12'h0, pipe_ctrl, pc_ld}, 32'h0);
      next_cycle();
    end
    icache_resp = 1; icache_rdata = 32'h00000013;
    #1;
    chk("late_i_release", {12'h0, pipe_ctrl, pc_ld}, {12'h0, 19'h7FFFF, 1'b1});

    // split completion: icache first, dcache three cycles later
    next_cycle();
    icache_read = 1; icache_resp = 1; icache_rdata = 32'h00A00093;
    dcache_req = 1; dcache_resp = 0;
    #1;
    chk("split_c1_req_en", {31'h0, icache_req_en}, 32'h1);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      icache_resp = 0; icache_rdata = 32'hDEADBEEF; dcache_resp = (c == 4);
      #1;
      chk("split_i_done", {31'h0, icache_req_en}, 32'h0);
      chk("split_ibuf", ifid_instr, 32'h00A00093);
    end
    chk("split_c4_advance", {13'h0, pipe_ctrl}, 32'h7FFFF);
    next_cycle();
    idle_inputs(); icache_rdata = 32'hDEADBEEF;
    #1;
    chk("split_c5_cleared", {31'h0, icache_req_en}, 32'h1);
    chk("split_c5_instr", ifid_instr, 32'hDEADBEEF);

    // load-use on rs2
    next_cycle();
    idex_is_load = 1; idex_rd = 5; ifid_rs2 = 5; ifid_uses_rs2 = 1; ifid_rs1 = 3; ifid_uses_rs1 = 1;
    #1;
    chk("lu_rs2", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, {10'h0, 19'h1FFFF, 3'b001});
    next_cycle();
    idex_rd = 0; ifid_rs2 = 0;
    #1;
    chk("lu_rd0", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, {10'h0, 19'h7FFFF, 3'b100});
    next_cycle();
    idex_rd = 3;
    #1;
    chk("lu_rs1", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, {10'h0, 19'h1FFFF, 3'b001});
    next_cycle();
    ifid_uses_rs1 = 0;
    #1;
    chk("lu_rs1_unused", {13'h0, pipe_ctrl}, 32'h7FFFF);

    // branch overrides load-use
    next_cycle();
    idex_rd = 5; ifid_rs2 = 5; br_taken = 1;
    #1;
    chk("br_over_lu", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, {10'h0, 19'h7FFFF, 3'b111});

    // branch and load-use ignored while memory stalls
    next_cycle();
    icache_read = 1;
    #1;
    chk("br_lu_frozen", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, 32'h0);
    next_cycle();
    icache_resp = 1;
    #1;
    chk("br_after_stall", {10'h0, pipe_ctrl, pc_ld, ifid_flush, idex_flush}, {10'h0, 19'h7FFFF, 3'b111});

    // reset in a WAIT cycle with i_done set
    next_cycle();
    idle_inputs();
    icache_read = 1; icache_resp = 1; icache_rdata = 32'h00001234; dcache_req = 1;
    next_cycle();
    icache_resp = 0; icache_rdata = 32'h55555555; rst = 1;
    #1;
    chk("rst_wait_outputs", {10'h0, pipe_ctrl, ifid_flush, idex_flush, icache_req_en, dcache_req_en},
        {10'h0, 19'h0, 4'b1100});
    next_cycle();
    rst = 0; dcache_req = 0;
    #1;
    chk("rst_cleared_i_done", {31'h0, icache_req_en}, 32'h1);
    chk("rst_cleared_instr", ifid_instr, 32'h55555555);
    chk("rst_then_stall", {13'h0, pipe_ctrl}, 32'h0);

`ifdef HAZARD_STALL_PERF_EN
    next_cycle();
    idle_inputs(); rst = 1;
    next_cycle();
    rst = 0; icache_read = 1;
    repeat (17) next_cycle();
    icache_read = 0;
    #1;
    chk("perf_mem_wrap", {28'h0, stall_mem_cnt}, 32'h1);
`endif

    next_cycle();
    idle_inputs();
    next_cycle();
    done = 1'b1;
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
